// File: rtl/wash_timer.sv
// wash_timer: phase timer for the washing-machine controller.
//
// A start from IDLE latches the selected duration into REMAINING. The timer then counts it
// down once every PRESCALE clock cycles. When the count expires it raises TIMER_DONE and
// holds it until the controller drops TIMER_EN. PAUSE freezes the count while the door is
// open. Dropping TIMER_EN aborts a run at any point.
//
// Ports:
//   CLK         system clock, rising edge
//   RST         synchronous active-high reset
//   TIMER_EN    run request (level) from the controller
//   TIMER_SEL   duration select, sampled only on the start edge
//   PAUSE       freeze counting while high
//   TIMER_DONE  registered, high in DONE
//   REMAINING   ticks left in the current run
//   BUSY        high in RUN or PAUSED
//   PAUSED      high in PAUSED
module wash_timer #(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned DUR_00   = 0,
  parameter int unsigned DUR_01   = 600,
  parameter int unsigned DUR_10   = 900,
  parameter int unsigned DUR_11   = 300
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TIMER_EN,
  input  logic [1:0]       TIMER_SEL,
  input  logic             PAUSE,
  output logic             TIMER_DONE,
  output logic [CNT_W-1:0] REMAINING,
  output logic             BUSY,
  output logic             PAUSED
);

  localparam int unsigned PreW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [PreW-1:0]  presc_q, presc_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             paused_q, paused_d;
  logic [CNT_W-1:0] start_dur;

  always_comb begin
    unique case (TIMER_SEL)
      2'b00:   start_dur = CNT_W'(DUR_00);
      2'b01:   start_dur = CNT_W'(DUR_01);
      2'b10:   start_dur = CNT_W'(DUR_10);
      default: start_dur = CNT_W'(DUR_11);
    endcase
  end

  // State register, including the registered status outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      presc_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      paused_q    <= paused_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    case (state_q)
      StIdle: begin
        if (TIMER_EN) begin
          remaining_d = start_dur;
          presc_d     = '0;
          state_d     = (start_dur == '0) ? StDone : StRun;
        end
      end
      StRun, StPaused: begin
        if (!TIMER_EN) begin
          // Abort wins over pause and over a coincident final tick.
          state_d     = StIdle;
          remaining_d = '0;
          presc_d     = '0;
        end else if (PAUSE) begin
          state_d = StPaused;
        end else begin
          // Leaving PAUSED counts on the same edge, so each paused cycle costs exactly one.
          state_d = StRun;
          if (presc_q == PreMax) begin
            presc_d = '0;
            if (remaining_q != '0) begin
              remaining_d = remaining_q - 1'b1;
            end
            if (remaining_q <= CNT_W'(1)) begin
              state_d = StDone;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
      end
      StDone: begin
        remaining_d = '0;
        if (!TIMER_EN) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        remaining_d = '0;
        presc_d     = '0;
      end
    endcase
  end

  // Output decode of the next state; registered alongside the state.
  always_comb begin
    done_d   = (state_d == StDone);
    busy_d   = (state_d == StRun) || (state_d == StPaused);
    paused_d = (state_d == StPaused);
  end

  assign TIMER_DONE = done_q;
  assign REMAINING  = remaining_q;
  assign BUSY       = busy_q;
  assign PAUSED     = paused_q;

endmodule

// File: tb/tb_wash_timer.sv
// Self-checking bench for wash_timer.
// The driver applies directed scenarios followed by random traffic. After every clock edge
// a reference model pushes the expected outputs into a queue. A monitor pops and compares
// them against the DUT on the falling edge.
module tb_wash_timer;

  localparam int unsigned P  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned D0 = 0;
  localparam int unsigned D1 = 3;
  localparam int unsigned D2 = 6;
  localparam int unsigned D3 = 2;

  logic         CLK;
  logic         RST;
  logic         TIMER_EN;
  logic [1:0]   TIMER_SEL;
  logic         PAUSE;
  logic         TIMER_DONE;
  logic [W-1:0] REMAINING;
  logic         BUSY;
  logic         PAUSED;

  wash_timer #(
    .PRESCALE (P),
    .CNT_W    (W),
    .DUR_00   (D0),
    .DUR_01   (D1),
    .DUR_10   (D2),
    .DUR_11   (D3)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .TIMER_EN   (TIMER_EN),
    .TIMER_SEL  (TIMER_SEL),
    .PAUSE      (PAUSE),
    .TIMER_DONE (TIMER_DONE),
    .REMAINING  (REMAINING),
    .BUSY       (BUSY),
    .PAUSED     (PAUSED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    bit done;
    bit busy;
    bit paused;
    int rem;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  // Reference model: a run is described by its duration and the number of counting cycles
  // it has received so far. Remaining time is derived arithmetically from those two values.
  int unsigned dur_tab[4] = '{D0, D1, D2, D3};
  int m_mode = 0;  // 0 idle, 1 active, 2 done
  int m_dur  = 0;
  int m_act  = 0;
  bit m_held = 0;

  function automatic void model_step(input bit r, input bit en, input logic [1:0] s,
                                     input bit p);
    exp_t e;
    if (r) begin
      m_mode = 0;
      m_act  = 0;
      m_held = 0;
    end else begin
      case (m_mode)
        0: if (en) begin
          m_dur  = int'(dur_tab[s]);
          m_act  = 0;
          m_held = 0;
          m_mode = (m_dur == 0) ? 2 : 1;
        end
        1: begin
          if (!en) begin
            m_mode = 0;
          end else if (p) begin
            m_held = 1;
          end else begin
            m_held = 0;
            m_act++;
            if (m_act == m_dur * int'(P)) m_mode = 2;
          end
        end
        default: if (!en) m_mode = 0;
      endcase
    end
    e.done   = (m_mode == 2);
    e.busy   = (m_mode == 1);
    e.paused = (m_mode == 1) && m_held;
    e.rem    = (m_mode == 1) ? (m_dur - m_act / int'(P)) : 0;
    sb.push_back(e);
  endfunction

  task automatic cyc(input bit r, input bit en, input logic [1:0] s, input bit p);
    RST       = r;
    TIMER_EN  = en;
    TIMER_SEL = s;
    PAUSE     = p;
    @(posedge CLK);
    model_step(r, en, s, p);
    #1;
  endtask

  task automatic run(input int n, input bit en, input logic [1:0] s, input bit p);
    for (int i = 0; i < n; i++) cyc(1'b0, en, s, p);
  endtask

  // Monitor: compares each expected entry against the DUT away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (TIMER_DONE !== e.done || BUSY !== e.busy || PAUSED !== e.paused ||
            REMAINING !== W'(e.rem)) begin
          n_fail++;
          $display("FAIL outputs @%0t: got done=%0b busy=%0b paused=%0b rem=%0d, want done=%0b busy=%0b paused=%0b rem=%0d",
                   $time, TIMER_DONE, BUSY, PAUSED, REMAINING, e.done, e.busy, e.paused,
                   e.rem);
        end
      end
    end
  end

  initial begin
    // Reset with inputs active: reset must win.
    cyc(1'b1, 1'b1, 2'b01, 1'b1);
    cyc(1'b1, 1'b0, 2'b00, 1'b0);
    run(2, 1'b0, 2'b01, 1'b1);

    // Basic run, held in DONE, then released.
    run(16, 1'b1, 2'b01, 1'b0);
    run(2, 1'b0, 2'b01, 1'b0);

    // Pause for 5 cycles starting at cycle 6.
    run(6, 1'b1, 2'b01, 1'b0);
    run(5, 1'b1, 2'b01, 1'b1);
    run(9, 1'b1, 2'b01, 1'b0);
    run(1, 1'b0, 2'b01, 1'b0);

    // Abort at cycle 5 of a long run.
    run(5, 1'b1, 2'b10, 1'b0);
    run(3, 1'b0, 2'b10, 1'b0);

    // Select toggled mid-run must not change the latched duration.
    cyc(1'b0, 1'b1, 2'b10, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 2'(i), 1'b0);
    run(1, 1'b0, 2'b00, 1'b0);

    // Zero duration goes straight to DONE.
    run(4, 1'b1, 2'b00, 1'b0);
    run(1, 1'b0, 2'b00, 1'b0);

    // Held through DONE for 20 extra cycles, then re-armed with a one-cycle low.
    run(D3 * P + 20, 1'b1, 2'b11, 1'b0);
    run(1, 1'b0, 2'b11, 1'b0);
    run(6, 1'b1, 2'b01, 1'b0);
    run(1, 1'b0, 2'b01, 1'b0);

    // Reset while paused, with enable and pause both still high.
    run(5, 1'b1, 2'b01, 1'b0);
    run(2, 1'b1, 2'b01, 1'b1);
    cyc(1'b1, 1'b1, 2'b01, 1'b1);
    run(3, 1'b1, 2'b01, 1'b1);
    run(2, 1'b0, 2'b01, 1'b0);

    // Abort on the terminal-tick cycle ends in IDLE, not DONE.
    run(D3 * P, 1'b1, 2'b11, 1'b0);
    run(3, 1'b0, 2'b11, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) != 0),
          2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 2));
    end
    run(2, 1'b0, 2'b00, 1'b0);

    // Allow the monitor to drain, bounded.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge CLK);
    @(negedge CLK);
    #1;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left in scoreboard, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/wash_timer.md
# wash_timer

Cycle timer that answers the washing-machine controller's timer request. It takes the controller's enable and duration-select outputs and counts the selected phase duration in prescaled ticks. It returns a registered done flag that the controller samples to leave its wash and spin phases. It also exposes the remaining time and run/pause status for the front panel, and freezes while the door is open.

## Interface
Parameters:
- PRESCALE, 1000 — CLK cycles per timer tick (>=1)
- CNT_W, 16 — width of tick counter and REMAINING
- DUR_00, 0 — duration in ticks for TIMER_SEL=00
- DUR_01, 600 — ticks for TIMER_SEL=01 (medium-level wash)
- DUR_10, 900 — ticks for TIMER_SEL=10 (high-level wash)
- DUR_11, 300 — ticks for TIMER_SEL=11 (spin)

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- TIMER_EN  in  1  level request from controller; high = run timer
- TIMER_SEL  in  2  duration select, sampled only at start
- PAUSE  in  1  high freezes counting (door open)
- TIMER_DONE  out  1  registered; high while in DONE state
- REMAINING  out  CNT_W  ticks left in current run
- BUSY  out  1  high in RUN or PAUSED
- PAUSED  out  1  high in PAUSED

## Operation
- States: IDLE, RUN, PAUSED, DONE. All outputs registered.
- Reset, when RST is high at an edge: state IDLE, TIMER_DONE=0, REMAINING=0, BUSY=0, PAUSED=0, prescaler=0. RST overrides all inputs.
- IDLE with TIMER_EN=1:
  - Latch D=DUR[TIMER_SEL] into REMAINING and clear the prescaler.
  - Go to RUN, or go directly to DONE if D=0.
- IDLE with TIMER_EN=0: stay. PAUSE is ignored.
- RUN:
  - Each non-paused cycle, the prescaler increments.
  - When the prescaler reaches PRESCALE-1 it wraps to 0 and REMAINING decrements by 1.
  - The decrement from 1 to 0 moves the state to DONE on the same edge.
- RUN with PAUSE=1: go to PAUSED. The prescaler and REMAINING hold, and no tick occurs that cycle.
- PAUSED with PAUSE=0: return to RUN and resume from the held prescaler value. No restart.
- Any of RUN, PAUSED or DONE with TIMER_EN=0: go to IDLE and set REMAINING=0. This is an abort in RUN/PAUSED and the normal release in DONE.
- TIMER_EN=0 has priority over PAUSE and over a coincident final tick. An abort on the terminal-tick cycle goes to IDLE, not DONE.
- DONE: hold with TIMER_DONE=1 and REMAINING=0 while TIMER_EN=1. There is no auto-restart. TIMER_EN must be low for at least one cycle to re-arm.
- TIMER_SEL changes after the start are ignored until the next start from IDLE.
- Arithmetic:
  - REMAINING never wraps below 0.
  - Every DUR_xx must fit in CNT_W.
  - The prescaler is clog2(PRESCALE) bits wide, with a minimum of 1.
  - PRESCALE=1 gives one tick per cycle.

## Timing
- TIMER_EN first sampled high at edge k (state IDLE):
  - Edge k: state=RUN, REMAINING=D, BUSY=1.
  - With no pauses, TIMER_DONE rises at edge k+D*PRESCALE.
- D=0: TIMER_DONE rises at edge k and BUSY stays 0.
- Each cycle spent in PAUSED, including the cycle PAUSE is first sampled, delays TIMER_DONE by exactly one cycle.
- TIMER_EN sampled low in DONE at edge m: TIMER_DONE=0 and state=IDLE at edge m.
- TIMER_EN held high through DONE→IDLE is impossible. DONE holds until TIMER_EN drops.
- REMAINING updates on the tick edge. It is visible the cycle after the tick condition.

## Test plan
- Basic: PRESCALE=4, DUR_01=3, TIMER_SEL=01, TIMER_EN high from edge 0.
  - RUN at edge 0 with REMAINING=3.
  - REMAINING=2/1/0 at edges 4/8/12.
  - TIMER_DONE=1 at edge 12 and held while TIMER_EN=1.
  - Dropping TIMER_EN clears TIMER_DONE the next edge.
- Pause: as the basic case, with PAUSE high for 5 cycles starting at cycle 6.
  - PAUSED=1 for 5 cycles.
  - REMAINING frozen at 2.
  - TIMER_DONE at edge 17.
- Abort and select change:
  - TIMER_EN low at cycle 5 of a TIMER_SEL=10 run → IDLE and REMAINING=0 next edge, with TIMER_DONE never asserted.
  - Toggling TIMER_SEL mid-run does not change REMAINING.
- Zero duration: TIMER_SEL=00 with DUR_00=0 → TIMER_DONE=1 at the start edge and BUSY=0 throughout.
- Re-arm: hold TIMER_EN high for 20 cycles after DONE → no restart and TIMER_DONE stays 1. A one-cycle low then high starts a fresh run with REMAINING=DUR[sel].
- Reset mid-run and priority:
  - RST high during PAUSED → all outputs 0 and state IDLE on that edge, even with TIMER_EN=1 and PAUSE=1.
  - TIMER_EN low on the terminal-tick cycle → IDLE with TIMER_DONE=0.
